// File: rtl/multicycle_ctrl.sv
// Main control sequencer for the multi-cycle MIPS datapath.
// One shared memory port. Memory states stretch on wait states. Illegal opcodes and memory timeouts halt the block in TRAP.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       retire_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic [3:0] state_o
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC += 4 on ready
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // MEM_ADDR | effective address for lw/sw
  // MEM_RD   | load data read, waits for ready
  // WB_MEM   | write MDR to rt
  // MEM_WR   | store data write, waits for ready
  // EXEC_R   | R-type ALU operation
  // WB_R     | write ALUOut to rd
  // BRANCH   | compare, conditional PC load
  // JUMP     | PC load with jump target
  // EXEC_I   | addi ALU operation
  // WB_I     | write ALUOut to rt
  // TRAP     | halted until reset
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    EXEC_I   = 4'd10,
    WB_I     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [7:0] W_LAST   = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] w_q, w_d;
  logic [1:0] cause_q, cause_d;
  logic       mem_state;
  logic       timed_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      w_q     <= 8'd0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cause_q <= cause_d;
    end
  end

  assign mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign timed_out = mem_state && !mem_ready_i && (w_q == W_LAST);

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 2'b00;
    retire_o     = 1'b0;
    trap_o       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'd3;
        case (opcode_i)
          OP_RTYPE:       state_d = EXEC_R;
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = EXEC_I;
          OP_J:           state_d = JUMP;
          default: begin
            state_d = TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        state_d     = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = WB_MEM;
      end
      WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = WB_R;
      end
      WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        state_d     = WB_I;
      end
      WB_I: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_src_o    = 2'd1;
        pc_write_o  = ((opcode_i == OP_BEQ) && zero_i) || ((opcode_i == OP_BNE) && !zero_i);
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd2;
        retire_o   = 1'b1;
        state_d    = FETCH;
      end
      TRAP: begin
        trap_o = 1'b1;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    if (timed_out) begin
      state_d = TRAP;
      cause_d = 2'b10;
    end

    // Reset wins combinationally so nothing is half-written in the reset cycle.
    if (rst_i) begin
      pc_write_o   = 1'b0;
      pc_src_o     = 2'd0;
      ir_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'd0;
      alu_op_o     = 2'b00;
      retire_o     = 1'b0;
      trap_o       = 1'b0;
    end
  end

  // Wait counter restarts whenever a memory state is entered; it only counts while stalled.
  always_comb begin
    w_d = w_q;
    if (state_d != state_q) begin
      w_d = 8'd0;
    end else if (mem_state && !mem_ready_i) begin
      w_d = w_q + 8'd1;
    end
  end

  assign trap_cause_o = rst_i ? 2'b00 : cause_q;
  assign state_o      = rst_i ? 4'd0 : state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control sequencer for the multi-cycle MIPS datapath. The single-cycle CPU uses split instruction and data memories; in this datapath one memory port is shared between instruction fetch and load/store. This block is a state machine that drives every datapath enable and mux select. It stretches memory states on wait states and traps on illegal opcodes or a memory timeout. It sits beside the datapath top level in place of the combinational Decoder, and still feeds the existing ALU_Ctrl through `alu_op_o`.

## Interface
- TIMEOUT, 16, maximum number of consecutive not-ready cycles tolerated in one memory state (legal range 2..255).

- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- opcode_i  in  6  IR[31:26]; stable from DECODE until the next FETCH completes
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  shared memory completes the current access this cycle
- pc_write_o  out  1  PC load enable
- pc_src_o  out  2  next-PC select: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target {PC[31:28], IR[25:0], 2'b00}
- ir_write_o  out  1  IR load enable
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg_o  out  1  writeback select: 0 = ALUOut, 1 = MDR
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b_o  out  2  ALU B select: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- alu_op_o  out  2  ALU_Ctrl operation: 00 = add, 01 = subtract, 10 = decode funct
- retire_o  out  1  one-cycle pulse in the last cycle of each instruction
- trap_o  out  1  block is halted in TRAP
- trap_cause_o  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
- state_o  out  4  current state encoding, for debug

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, WB_MEM 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11, TRAP 12.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives mem_read=1, iord=0, src_a=0, src_b=1, alu_op=00.
  - ir_write, pc_write (pc_src=0) assert only in the cycle mem_ready_i=1; the FSM then moves to DECODE.
- DECODE: drives src_a=0, src_b=3, alu_op=00, precomputing the branch target into ALUOut. Next state by opcode_i:
  - 0x00 → EXEC_R
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR
  - 0x04 (beq) or 0x05 (bne) → BRANCH
  - 0x08 (addi) → EXEC_I
  - 0x02 (j) → JUMP
  - any other value → TRAP with cause 01
- MEM_ADDR: src_a=1, src_b=2, alu_op=00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; waits for ready, then goes to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, retire; next state FETCH.
- MEM_WR: mem_write=1, iord=1, held until ready; retires in the ready cycle, then goes to FETCH.
- EXEC_R: src_a=1, src_b=0, alu_op=10. WB_R: reg_write=1, reg_dst=1, retire.
- EXEC_I: src_a=1, src_b=2, alu_op=00. WB_I: reg_write=1, reg_dst=0, retire.
- BRANCH:
  - Drives src_a=1, src_b=0, alu_op=01, pc_src=1.
  - pc_write = (beq & zero_i) | (bne & ~zero_i).
  - Retires; next state FETCH.
- JUMP: pc_write=1, pc_src=2, retire; next state FETCH.
- Memory timeout:
  - 8-bit wait counter w clears on entry to FETCH, MEM_RD or MEM_WR.
  - Each cycle with mem_ready_i=0 and w<TIMEOUT-1: w increments and the FSM stays.
  - mem_ready_i=0 with w=TIMEOUT-1: next state TRAP, cause 10.
  - mem_ready_i=1 at any w, including TIMEOUT-1, completes the access normally.
- TRAP: all enables and strobes 0, trap_o=1, trap_cause_o held. Only rst_i exits TRAP.

## Timing
- Outputs are combinational from the registered state, plus the mem_ready_i / zero_i / opcode_i qualifications above. No output is registered.
- While rst_i=1: state=FETCH, w=0, trap_cause_o=00, and every enable/strobe (pc_write, ir_write, mem_read, mem_write, reg_write, retire, trap) is forced to 0. All selects read 0 and state_o reads 0.
- The first fetch strobe appears in the first cycle with rst_i=0.
- Reset asserted mid-instruction or in TRAP takes effect at the next edge with no partial writes. A mem_write_o in progress drops in the reset cycle.
- Cycles per instruction with zero wait states:
  - R-type and addi: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j: 3
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- retire_o pulses exactly once per completed instruction and never in FETCH, DECODE or TRAP.

## Test plan
- Reset, then add $3,$1,$2 with ready always 1 → states 0,1,6,7. reg_write=1 with reg_dst=1 in cycle 4; retire_o high in cycle 4 only; back in FETCH in cycle 5.
- lw with ready low 3 cycles in MEM_RD → sequence 0,1,2,3,3,3,3,4. mem_read and iord stay 1 throughout MEM_RD; mem_to_reg=1 in WB_MEM.
- beq with zero_i=1 → pc_write=1, pc_src=1 in BRANCH. bne with zero_i=1 → pc_write=0. Both take 3 cycles.
- Opcode 0x3F → TRAP after DECODE, trap_cause_o=01. Outputs stay quiet for 20 cycles; rst_i for 1 cycle returns the FSM to FETCH with cause 00.
- TIMEOUT=16, ready low for 16 FETCH cycles → TRAP with cause 10. Ready high on the 16th cycle instead → ir_write pulses and the FSM goes to DECODE.
- sw with rst_i asserted on its second MEM_WR wait cycle → mem_write_o=0 in that cycle; state 0 and all strobes 0 on the next edge.
